// File: rtl/controlador_memoria_dados_if.sv
// Data-side bus between the nRisc core (master) and the data-memory controller (slave).
interface controlador_memoria_dados_if #(
  parameter int unsigned LARG_END = 8
);
  logic [LARG_END-1:0] end_mem_dados;
  logic [7:0]          dado_escrito_mem;
  logic                esc_mem;
  logic                ler_mem;
  logic [7:0]          dado_lido_mem;
  logic                ocupado;
  logic                pronto;

  modport master (
    output end_mem_dados, dado_escrito_mem, esc_mem, ler_mem,
    input  dado_lido_mem, ocupado, pronto
  );

  modport slave (
    input  end_mem_dados, dado_escrito_mem, esc_mem, ler_mem,
    output dado_lido_mem, ocupado, pronto
  );
endinterface

// File: rtl/controlador_memoria_dados.sv
// 2**LARG_END x 8 data memory with a request/ready handshake and LATENCIA-cycle access.
// Optional last-write hit path enabled by CONTROLADOR_MEMORIA_DADOS_ACERTO_EN.
module controlador_memoria_dados #(
  parameter int unsigned LATENCIA = 2,
  parameter int unsigned LARG_END = 8
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  controlador_memoria_dados_if.slave   io_bus
);

  typedef enum logic [1:0] {StOcioso, StEspera, StConclui} estado_e;

  estado_e             r_estado;
  estado_e             w_prox_estado;
  logic [3:0]          r_cont;
  logic [LARG_END-1:0] r_end;
  logic [7:0]          r_dado;
  logic                r_esc;
  logic                r_ler;
  logic [7:0]          r_dado_lido;
  logic [7:0]          r_mem [2**LARG_END];

  logic                w_req;
  logic                w_aceita;
  logic                w_commit;
  logic                w_acerto;
  logic [7:0]          w_dado_acerto;

  assign w_req = io_bus.esc_mem | io_bus.ler_mem;

`ifdef CONTROLADOR_MEMORIA_DADOS_ACERTO_EN
  logic [LARG_END-1:0] r_ult_end;
  logic [7:0]          r_ult_dado;
  logic                r_ult_valido;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ult_valido <= 1'b0;
      r_ult_end    <= '0;
      r_ult_dado   <= '0;
    end else if (w_commit && r_esc) begin
      r_ult_valido <= 1'b1;
      r_ult_end    <= r_end;
      r_ult_dado   <= r_dado;
    end
  end

  // Only pure reads may bypass; writes and combined requests pay full latency.
  assign w_acerto      = io_bus.ler_mem & ~io_bus.esc_mem & r_ult_valido &
                         (io_bus.end_mem_dados == r_ult_end);
  assign w_dado_acerto = r_ult_dado;
`else
  assign w_acerto      = 1'b0;
  assign w_dado_acerto = 8'h00;
`endif

  always_comb begin
    w_prox_estado = r_estado;
    w_aceita      = 1'b0;
    w_commit      = 1'b0;
    unique case (r_estado)
      StOcioso: begin
        if (w_req) begin
          w_aceita      = 1'b1;
          w_prox_estado = w_acerto ? StConclui : StEspera;
        end
      end
      // LATENCIA=1 still spends one edge here so Pronto always follows edge E0+LATENCIA.
      StEspera: begin
        if (r_cont == 4'd0) begin
          w_commit      = 1'b1;
          w_prox_estado = StConclui;
        end
      end
      StConclui: w_prox_estado = StOcioso;
      default:   w_prox_estado = StOcioso;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado    <= StOcioso;
      r_cont      <= 4'd0;
      r_end       <= '0;
      r_dado      <= 8'h00;
      r_esc       <= 1'b0;
      r_ler       <= 1'b0;
      r_dado_lido <= 8'h00;
    end else begin
      r_estado <= w_prox_estado;
      if (w_aceita) begin
        r_end  <= io_bus.end_mem_dados;
        r_dado <= io_bus.dado_escrito_mem;
        r_esc  <= io_bus.esc_mem;
        r_ler  <= io_bus.ler_mem;
        r_cont <= 4'(LATENCIA - 1);
      end else if (r_estado == StEspera && r_cont != 4'd0) begin
        r_cont <= r_cont - 4'd1;
      end
      if (w_commit && r_ler) begin
        r_dado_lido <= r_esc ? r_dado : r_mem[r_end];
      end else if (w_aceita && w_acerto) begin
        r_dado_lido <= w_dado_acerto;
      end
    end
  end

  // Storage has no reset: contents survive ResetN, and an aborted write never commits.
  always_ff @(posedge i_clk) begin
    if (w_commit && r_esc) begin
      r_mem[r_end] <= r_dado;
    end
  end

  assign io_bus.dado_lido_mem = r_dado_lido;
  assign io_bus.ocupado       = (r_estado == StEspera);
  assign io_bus.pronto        = (r_estado == StConclui);

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Directed bench: three controllers with LATENCIA 2, 4 and 8 on a shared clock and reset.
module tb_controlador_memoria_dados;

`ifdef CONTROLADOR_MEMORIA_DADOS_ACERTO_EN
  localparam bit Acerto = 1'b1;
`else
  localparam bit Acerto = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [2:0][7:0] t_end;
  logic [2:0][7:0] t_wd;
  logic [2:0]      t_esc;
  logic [2:0]      t_ler;
  logic [2:0][7:0] o_rd;
  logic [2:0]      o_oc;
  logic [2:0]      o_pr;
  int              checks;
  int              errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    controlador_memoria_dados_if #(.LARG_END(8)) bus ();
    assign bus.end_mem_dados    = t_end[g];
    assign bus.dado_escrito_mem = t_wd[g];
    assign bus.esc_mem          = t_esc[g];
    assign bus.ler_mem          = t_ler[g];
    assign o_rd[g]              = bus.dado_lido_mem;
    assign o_oc[g]              = bus.ocupado;
    assign o_pr[g]              = bus.pronto;

    controlador_memoria_dados #(
      .LATENCIA((g == 0) ? 2 : ((g == 1) ? 4 : 8)),
      .LARG_END(8)
    ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int s, input logic esc, input logic ler,
                         input logic [7:0] a, input logic [7:0] d);
    t_end[s] = a;
    t_wd[s]  = d;
    t_esc[s] = esc;
    t_ler[s] = ler;
    step();
    t_esc[s] = 1'b0;
    t_ler[s] = 1'b0;
  endtask

  // Edges counted after the accepting edge until Pronto is seen; 20 means timeout.
  task automatic wait_pronto(input int s, output int n);
    n = 0;
    while (o_pr[s] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    t_end = '0; t_wd = '0; t_esc = '0; t_ler = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (o_rd[s] !== 8'h00) begin
        errors++; $display("FAIL reset_rd[%0d]: got %h, required 00", s, o_rd[s]);
      end
      checks++;
      if (o_oc[s] !== 1'b0) begin
        errors++; $display("FAIL reset_ocupado[%0d]: got %b, required 0", s, o_oc[s]);
      end
      checks++;
      if (o_pr[s] !== 1'b0) begin
        errors++; $display("FAIL reset_pronto[%0d]: got %b, required 0", s, o_pr[s]);
      end
    end
  endtask

  task automatic test_write_read();
    int n;
    request(0, 1'b1, 1'b0, 8'h10, 8'hA5);
    checks++;
    if (o_oc[0] !== 1'b1 || o_pr[0] !== 1'b0) begin
      errors++; $display("FAIL wr_busy: ocupado=%b pronto=%b, required 1 0", o_oc[0], o_pr[0]);
    end
    wait_pronto(0, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL wr_latency: got %0d, required 2", n); end
    checks++;
    if (o_rd[0] !== 8'h00) begin
      errors++; $display("FAIL wr_rd_unchanged: got %h, required 00", o_rd[0]);
    end
    checks++;
    if (o_oc[0] !== 1'b0) begin
      errors++; $display("FAIL wr_ocupado_at_pronto: got %b, required 0", o_oc[0]);
    end
    step();
    checks++;
    if (o_pr[0] !== 1'b0) begin
      errors++; $display("FAIL pronto_pulse: got %b, required 0", o_pr[0]);
    end
    request(0, 1'b0, 1'b1, 8'h10, 8'h00);
    wait_pronto(0, n);
    checks++;
    if (n !== (Acerto ? 0 : 2)) begin
      errors++; $display("FAIL rd_latency: got %0d, required %0d", n, Acerto ? 0 : 2);
    end
    checks++;
    if (o_rd[0] !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h, required A5", o_rd[0]); end
    step();
  endtask

  task automatic test_ignored_inputs();
    int n;
    request(1, 1'b1, 1'b0, 8'h10, 8'hA5);
    wait_pronto(1, n);
    step();
    request(1, 1'b1, 1'b0, 8'h20, 8'h99);
    wait_pronto(1, n);
    step();
    request(1, 1'b0, 1'b1, 8'h10, 8'h00);
    t_end[1] = 8'h20;
    t_esc[1] = 1'b1;
    step();
    t_esc[1] = 1'b0;
    step();
    t_esc[1] = 1'b1;
    wait_pronto(1, n);
    checks++;
    if (n + 2 !== 4) begin errors++; $display("FAIL ign_latency: got %0d, required 4", n + 2); end
    checks++;
    if (o_rd[1] !== 8'hA5) begin errors++; $display("FAIL ign_data: got %h, required A5", o_rd[1]); end
    step();
    checks++;
    if (o_oc[1] !== 1'b0) begin
      errors++; $display("FAIL conclui_req_ignored: ocupado=%b, required 0", o_oc[1]);
    end
    t_esc[1] = 1'b0;
    step();
    request(1, 1'b0, 1'b1, 8'h20, 8'h00);
    wait_pronto(1, n);
    checks++;
    if (n !== (Acerto ? 0 : 4)) begin
      errors++; $display("FAIL ign_rd20_latency: got %0d, required %0d", n, Acerto ? 0 : 4);
    end
    checks++;
    if (o_rd[1] !== 8'h99) begin
      errors++; $display("FAIL ign_array20: got %h, required 99", o_rd[1]);
    end
    step();
  endtask

  task automatic test_combined();
    int n;
    request(0, 1'b1, 1'b1, 8'hFF, 8'h3C);
    wait_pronto(0, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL comb_latency: got %0d, required 2", n); end
    checks++;
    if (o_rd[0] !== 8'h3C) begin errors++; $display("FAIL comb_data: got %h, required 3C", o_rd[0]); end
    step();
    request(0, 1'b1, 1'b0, 8'h11, 8'hEE);
    wait_pronto(0, n);
    checks++;
    if (o_rd[0] !== 8'h3C) begin
      errors++; $display("FAIL wr_only_keeps_rd: got %h, required 3C", o_rd[0]);
    end
    step();
    request(0, 1'b0, 1'b1, 8'hFF, 8'h00);
    wait_pronto(0, n);
    checks++;
    if (o_rd[0] !== 8'h3C) begin errors++; $display("FAIL comb_arrayFF: got %h, required 3C", o_rd[0]); end
    step();
  endtask

  task automatic test_reset_mid_write();
    int n;
    request(0, 1'b1, 1'b0, 8'h05, 8'h11);
    wait_pronto(0, n);
    step();
    request(0, 1'b1, 1'b0, 8'h05, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_rd[0] !== 8'h00 || o_oc[0] !== 1'b0 || o_pr[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rd=%h oc=%b pr=%b, required 00 0 0",
               o_rd[0], o_oc[0], o_pr[0]);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    request(0, 1'b0, 1'b1, 8'h05, 8'h00);
    wait_pronto(0, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL mid_reset_latency: got %0d, required 2", n); end
    checks++;
    if (o_rd[0] !== 8'h11) begin
      errors++; $display("FAIL mid_reset_preserved: got %h, required 11", o_rd[0]);
    end
    step();
  endtask

  task automatic test_latency8();
    int n;
    request(2, 1'b1, 1'b0, 8'h40, 8'h5A);
    wait_pronto(2, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL l8_wr_latency: got %0d, required 8", n); end
    step();
    request(2, 1'b0, 1'b1, 8'h40, 8'h00);
    wait_pronto(2, n);
    checks++;
    if (n !== (Acerto ? 0 : 8)) begin
      errors++; $display("FAIL l8_rd40_latency: got %0d, required %0d", n, Acerto ? 0 : 8);
    end
    checks++;
    if (o_rd[2] !== 8'h5A) begin errors++; $display("FAIL l8_rd40_data: got %h, required 5A", o_rd[2]); end
    step();
    request(2, 1'b0, 1'b1, 8'h41, 8'h00);
    wait_pronto(2, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL l8_rd41_latency: got %0d, required 8", n); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_ignored_inputs();
    test_combined();
    test_reset_mid_write();
    test_latency8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
